reg_bus_core: RTL

Parametrised single-bus datapath core for the single-core processor: a GPR file of configurable depth and width plus the PC, IR, MAR, MDR, Y and 64-bit Z special registers, all sharing one internal bus. The core contains a memory handshake FSM that moves data between the MDR and external memory under MAR addressing. It sits between the control unit, which drives all enables, and the ALU and memory, and it replaces hard-wired per-register bus wiring.

---
 rtl/reg_bus_core.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/reg_bus_core.sv
// Single-bus register datapath: GPR file, PC/IR/MAR/MDR/Y/Z and a memory handshake FSM.
// Optional REG_BUS_CONFLICT_EN adds multi-driver detection on the internal bus.
module reg_bus_core #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_GPR = 16,
    parameter int unsigned PC_STEP = 1,
    parameter int unsigned SEL_W   = $clog2(NUM_GPR)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_pc_in,
    input  logic                i_pc_out,
    input  logic                i_inc_pc,
    input  logic                i_ir_in,
    input  logic                i_mar_in,
    input  logic                i_mdr_in,
    input  logic                i_mdr_out,
    input  logic                i_y_in,
    input  logic                i_y_out,
    input  logic                i_z_in,
    input  logic                i_zlo_out,
    input  logic                i_zhi_out,
    input  logic [2*DATA_W-1:0] i_alu_result,
    input  logic                i_gpr_in,
    input  logic                i_gpr_out,
    input  logic [SEL_W-1:0]    i_gpr_wsel,
    input  logic [SEL_W-1:0]    i_gpr_rsel,
    input  logic                i_ext_out,
    input  logic [DATA_W-1:0]   i_ext_data,
    input  logic                i_mem_rd,
    input  logic                i_mem_wr,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [DATA_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic                o_mem_busy,
    output logic                o_mem_done,
    output logic [DATA_W-1:0]   o_ir_q,
    output logic [DATA_W-1:0]   o_y_q,
    output logic [DATA_W-1:0]   o_pc_q,
    output logic [DATA_W-1:0]   o_bus,
    output logic                o_bus_conflict,
    output logic                o_conflict_seen
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} mem_state_e;

    logic [DATA_W-1:0]   r_pc, r_ir, r_mar, r_mdr, r_y;
    logic [2*DATA_W-1:0] r_z;
    logic [DATA_W-1:0]   r_gpr [NUM_GPR];
    logic [DATA_W-1:0]   w_gpr_rdata;
    logic [DATA_W-1:0]   w_bus;
    mem_state_e          r_state;
    logic                r_mem_req, r_mem_we, r_mem_busy, r_mem_done;

    // Out-of-range read index falls through to zero.
    always_comb begin
        w_gpr_rdata = '0;
        for (int i = 0; i < int'(NUM_GPR); i++) begin
            if (i_gpr_rsel == SEL_W'(i)) w_gpr_rdata = r_gpr[i];
        end
    end

    always_comb begin
        w_bus = '0;
        if (i_pc_out)       w_bus = r_pc;
        else if (i_mdr_out) w_bus = r_mdr;
        else if (i_zlo_out) w_bus = r_z[DATA_W-1:0];
        else if (i_zhi_out) w_bus = r_z[2*DATA_W-1:DATA_W];
        else if (i_y_out)   w_bus = r_y;
        else if (i_gpr_out) w_bus = w_gpr_rdata;
        else if (i_ext_out) w_bus = i_ext_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_y   <= '0;
            r_z   <= '0;
        end else begin
            if (i_pc_in)       r_pc <= w_bus;
            else if (i_inc_pc) r_pc <= r_pc + DATA_W'(PC_STEP);
            if (i_ir_in)  r_ir  <= w_bus;
            if (i_mar_in) r_mar <= w_bus;
            if (i_y_in)   r_y   <= w_bus;
            if (i_z_in)   r_z   <= i_alu_result;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < int'(NUM_GPR); i++) begin
            if (!i_reset) r_gpr[i] <= '0;
            else if (i_gpr_in && i_gpr_wsel == SEL_W'(i)) r_gpr[i] <= w_bus;
        end
    end

    // Memory read data has priority over a bus load in the acknowledging cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset)                                       r_mdr <= '0;
        else if (r_state == StWait && i_mem_ack && !r_mem_we) r_mdr <= i_mem_rdata;
        else if (i_mdr_in)                                  r_mdr <= w_bus;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_busy <= 1'b0;
            r_mem_done <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_mem_rd || i_mem_wr) begin
                        r_state    <= StWait;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= !i_mem_rd;
                        r_mem_busy <= 1'b1;
                    end
                end
                StWait: begin
                    if (i_mem_ack) begin
                        r_state    <= StDone;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_done <= 1'b1;
                    end
                end
                StDone: begin
                    r_state    <= StIdle;
                    r_mem_done <= 1'b0;
                    r_mem_busy <= 1'b0;
                end
                default: begin
                    r_state    <= StIdle;
                    r_mem_req  <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_mem_busy <= 1'b0;
                    r_mem_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef REG_BUS_CONFLICT_EN
    logic [6:0] w_drv;
    logic       r_conflict_seen;

    assign w_drv = {i_pc_out, i_mdr_out, i_zlo_out, i_zhi_out, i_y_out, i_gpr_out, i_ext_out};
    // More than one bit set means clearing the lowest set bit leaves something.
    assign o_bus_conflict = |(w_drv & (w_drv - 7'd1));

    always_ff @(posedge i_clk) begin
        if (!i_reset)            r_conflict_seen <= 1'b0;
        else if (o_bus_conflict) r_conflict_seen <= 1'b1;
    end
    assign o_conflict_seen = r_conflict_seen;
`else
    assign o_bus_conflict  = 1'b0;
    assign o_conflict_seen = 1'b0;
`endif

    assign o_bus       = w_bus;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_busy  = r_mem_busy;
    assign o_mem_done  = r_mem_done;
    assign o_mem_addr  = r_mar;
    assign o_mem_wdata = r_mdr;
    assign o_ir_q      = r_ir;
    assign o_y_q       = r_y;
    assign o_pc_q      = r_pc;

endmodule
